// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//
// Measures an asynchronous PWM/TTL input and reports, once per completed input
// period, the period length, the high time (both in clk cycles) and the
// fractional duty cycle floor(high_time * 2^DUTY_W / period).
//
// Ports
//   clk          in   1       system clock, all logic on posedge
//   rst_n        in   1       asynchronous active-low reset
//   pwm_in       in   1       asynchronous PWM input (pad level)
//   duty         out  DUTY_W  last duty result
//   period       out  CNT_W   last period, clk cycles
//   high_time    out  CNT_W   last high time, clk cycles
//   valid        out  1       1-cycle strobe, results update on this cycle
//   overrun      out  1       1-cycle strobe, a completed period was dropped
//   stuck        out  1       no input edge for 2^CNT_W-1 cycles (level)
//   stuck_level  out  1       synchronized input level when stuck was set
// ---------------------------------------------------------------------------
module pwm_duty_decoder #(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              valid,
    output logic              overrun,
    output logic              stuck,
    output logic              stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int               IT_W    = $clog2(DUTY_W + 1);
    localparam logic [IT_W-1:0]  IT_LOAD = IT_W'(DUTY_W);
    localparam logic [IT_W-1:0]  IT_ONE  = IT_W'(1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // ---- input synchronizer and edge detect --------------------------------
    logic sync1_q;
    logic s_q;
    logic s_dly_q;
    logic rise;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            s_q     <= sync1_q;
            s_dly_q <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;
    assign fall = ~s_q & s_dly_q;

    // ---- measurement FSM ---------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic             complete;

    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
        end
    end

    // Timeout has priority over any edge seen in the same cycle; on timeout
    // the counter simply holds (SYNC does not count).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        case (state_q)
            ST_SYNC: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (timeout) begin
                    state_d = ST_SYNC;
                end else begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_d    = cnt_q;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (timeout) begin
                    state_d = ST_SYNC;
                end else if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // A rise in LOW closes the {hi, period} pair; period is cnt_q itself.
    always_comb begin
        timeout  = 1'b0;
        complete = 1'b0;
        if ((state_q == ST_HIGH) || (state_q == ST_LOW)) begin
            timeout = (cnt_q == CNT_MAX);
        end
        if ((state_q == ST_LOW) && rise && !timeout) begin
            complete = 1'b1;
        end
    end

    // ---- restoring divider -------------------------------------------------
    logic [CNT_W-1:0]  r_q;
    logic [DUTY_W-1:0] q_q;
    logic [CNT_W-1:0]  dper_q;
    logic [CNT_W-1:0]  dhi_q;
    logic [IT_W-1:0]   it_q;
    logic              busy;
    logic              last_it;
    logic [CNT_W:0]    r_sh;
    logic              ge;
    logic [CNT_W-1:0]  r_nx;
    logic [DUTY_W-1:0] q_nx;

    assign busy    = (it_q != '0);
    assign last_it = (it_q == IT_ONE);

    // The remainder stays below the divisor, so it is stored in CNT_W bits;
    // only the doubled value needs the extra bit for the compare. The
    // subtraction is taken modulo 2^CNT_W since its true result is < dper_q.
    assign r_sh = {r_q, 1'b0};
    assign ge   = (r_sh >= {1'b0, dper_q});
    assign r_nx = ge ? ({r_q[CNT_W-2:0], 1'b0} - dper_q) : {r_q[CNT_W-2:0], 1'b0};
    assign q_nx = (q_q << 1) | DUTY_W'(ge);

    logic [DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  high_q;
    logic              valid_q;
    logic              overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            q_q       <= '0;
            dper_q    <= '0;
            dhi_q     <= '0;
            it_q      <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            if (complete) begin
                if (busy) begin
                    overrun_q <= 1'b1;
                end else begin
                    r_q    <= hi_q;
                    q_q    <= '0;
                    dper_q <= cnt_q;
                    dhi_q  <= hi_q;
                    it_q   <= IT_LOAD;
                end
            end
            if (busy) begin
                r_q  <= r_nx;
                q_q  <= q_nx;
                it_q <= it_q - IT_ONE;
                // Final iteration publishes the finished quotient directly so
                // valid lands DUTY_W+1 cycles after the registered rise.
                if (last_it) begin
                    duty_q   <= q_nx;
                    period_q <= dper_q;
                    high_q   <= dhi_q;
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    // ---- stuck indication --------------------------------------------------
    logic stuck_q;
    logic stuck_lvl_q;

    // A fresh timeout outranks a result finishing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else if (timeout) begin
            stuck_q     <= 1'b1;
            stuck_lvl_q <= s_q;
        end else if (busy && last_it) begin
            stuck_q <= 1'b0;
        end
    end

    assign duty        = duty_q;
    assign period      = period_q;
    assign high_time   = high_q;
    assign valid       = valid_q;
    assign overrun     = overrun_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;

    localparam int CNT_W  = 10;
    localparam int DUTY_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              valid;
    logic              overrun;
    logic              stuck;
    logic              stuck_level;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .duty        (duty),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .overrun     (overrun),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    typedef struct {
        int hi;
        int lo;
        int nper;
        int exp_per;
        int exp_hi;
        int exp_duty;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ovr = 0;
    logic saw_valid = 1'b0;
    int exp_per = 0;
    int exp_hi = 0;
    int exp_duty = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: sample on the falling edge, score any result strobe.
    task automatic tick();
        @(negedge clk);
        saw_valid = valid;
        if (valid === 1'b1) begin
            n_valid++;
            check("valid_period", 64'(period), 64'(exp_per));
            check("valid_high_time", 64'(high_time), 64'(exp_hi));
            check("valid_duty", 64'(duty), 64'(exp_duty));
            check("valid_stuck_clear", 64'(stuck), 64'd0);
        end
        if (overrun === 1'b1) n_ovr++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_pwm(input int hi, input int lo, input int nper);
        for (int p = 0; p < nper; p++) begin
            pwm_in = 1'b1;
            ticks(hi);
            pwm_in = 1'b0;
            ticks(lo);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(3);
    endtask

    initial begin
        int v0;
        int o0;
        int lat;
        bit found;

        vecs[0] = '{25,   75,   4, 100,  25,   64};
        vecs[1] = '{10,   30,   3, 40,   10,   64};
        vecs[2] = '{50,   50,   3, 100,  50,   128};
        vecs[3] = '{3,    7,    3, 10,   3,    76};
        vecs[4] = '{1,    9,    3, 10,   1,    25};
        vecs[5] = '{9,    1,    3, 10,   9,    230};
        vecs[6] = '{4,    5,    4, 9,    4,    113};
        vecs[7] = '{510,  512,  2, 1022, 510,  127};
        vecs[8] = '{1,    1021, 2, 1022, 1,    0};
        vecs[9] = '{1021, 1,    2, 1022, 1021, 255};

        // Outputs stay zero under reset regardless of input activity.
        tick();
        for (int i = 0; i < 20; i++) begin
            pwm_in = 1'($urandom_range(0, 1));
            tick();
            check("reset_outputs_zero",
                  64'({duty, period, high_time, valid, overrun, stuck, stuck_level}), 64'd0);
        end
        pwm_in = 1'b0;
        rst_n  = 1'b1;
        ticks(50);
        check("no_valid_after_release", 64'(n_valid), 64'd0);
        check("no_stuck_input_low_sync", 64'(stuck), 64'd0);

        // Table of steady PWM patterns; each first rise only arms the FSM.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            exp_per  = vecs[i].exp_per;
            exp_hi   = vecs[i].exp_hi;
            exp_duty = vecs[i].exp_duty;
            v0 = n_valid;
            o0 = n_ovr;
            run_pwm(vecs[i].hi, vecs[i].lo, vecs[i].nper);
            ticks(12);
            check("vec_valid_count", 64'(n_valid - v0), 64'(vecs[i].nper - 1));
            check("vec_overrun_count", 64'(n_ovr - o0), 64'd0);
        end

        // Latency: 2 synchronizer cycles plus DUTY_W+1 after the registered rise.
        do_reset();
        exp_per = 100; exp_hi = 25; exp_duty = 64;
        run_pwm(25, 75, 1);
        pwm_in = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (!found) begin
                tick();
                if (saw_valid) begin
                    found = 1'b1;
                    lat = c;
                end
            end
        end
        check("valid_latency_from_pin", 64'(lat), 64'd11);

        // Period 3 is shorter than the divider: two of every three pairs drop.
        do_reset();
        exp_per = 3; exp_hi = 1; exp_duty = 85;
        v0 = n_valid;
        o0 = n_ovr;
        run_pwm(1, 2, 61);
        ticks(15);
        check("fast_valid_count", 64'(n_valid - v0), 64'd20);
        check("fast_overrun_count", 64'(n_ovr - o0), 64'd40);

        // Input stuck high: timeout exactly at cnt = 1023.
        do_reset();
        v0 = n_valid;
        pwm_in = 1'b1;
        ticks(1025);
        check("stuck_not_yet", 64'(stuck), 64'd0);
        tick();
        check("stuck_high_set", 64'(stuck), 64'd1);
        check("stuck_level_high", 64'(stuck_level), 64'd1);
        ticks(80);
        check("stuck_no_valid", 64'(n_valid - v0), 64'd0);
        exp_per = 40; exp_hi = 10; exp_duty = 64;
        v0 = n_valid;
        run_pwm(10, 30, 3);
        ticks(12);
        check("resume_valid_count", 64'(n_valid - v0), 64'd1);
        check("resume_stuck_cleared", 64'(stuck), 64'd0);

        // Input stuck low after one pulse.
        do_reset();
        v0 = n_valid;
        pwm_in = 1'b1;
        ticks(10);
        pwm_in = 1'b0;
        ticks(1100);
        check("stuck_low_set", 64'(stuck), 64'd1);
        check("stuck_level_low", 64'(stuck_level), 64'd0);
        check("stuck_low_no_valid", 64'(n_valid - v0), 64'd0);

        // A 1023-cycle period hits the timeout on the closing rise.
        do_reset();
        v0 = n_valid;
        run_pwm(511, 512, 2);
        ticks(5);
        check("long_period_stuck", 64'(stuck), 64'd1);
        check("long_period_level", 64'(stuck_level), 64'd1);
        check("long_period_no_valid", 64'(n_valid - v0), 64'd0);

        // Reset four cycles into a division.
        do_reset();
        exp_per = 100; exp_hi = 25; exp_duty = 64;
        run_pwm(25, 75, 3);
        check("pre_reset_period", 64'(period), 64'd100);
        pwm_in = 1'b1;
        ticks(6);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs_zero",
              64'({duty, period, high_time, valid, overrun, stuck, stuck_level}), 64'd0);
        v0 = n_valid;
        ticks(20);
        rst_n = 1'b1;
        ticks(20);
        pwm_in = 1'b0;
        ticks(75);
        check("midreset_no_early_valid", 64'(n_valid - v0), 64'd0);
        exp_per = 95; exp_hi = 20; exp_duty = 53;
        pwm_in = 1'b1;
        ticks(15);
        check("midreset_first_valid", 64'(n_valid - v0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
